// File: rtl/dmem_responder_if.sv
// Memory-stage load/store bus between the core (master) and the data memory
// responder (slave).
interface dmem_responder_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        BusyM;
    logic        DoneM;
    logic        ErrM;

    modport master (
        output MemReqM, MemWriteM, funct3M, ALUResultM, WriteDataM,
        input  ReadDataM, BusyM, DoneM, ErrM
    );

    modport slave (
        input  MemReqM, MemWriteM, funct3M, ALUResultM, WriteDataM,
        output ReadDataM, BusyM, DoneM, ErrM
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores into a word array,
// with a configurable number of wait states and a busy/done handshake.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state_r;
    logic [2:0]      cnt_r;
    logic            write_r;
    logic [2:0]      funct3_r;
    logic [1:0]      offs_r;
    logic [AW-1:0]   index_r;
    logic [31:0]     wdata_r;
    logic [31:0]     rdata_r;
    logic            done_r;
    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            err_s;
    logic            accept_s;
    logic            busy_s;
    logic            mem_op_s;
    logic [3:0]      lanes_s;
    logic            unused_addr_hi_s;

    function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3)
            3'b000:  m = 4'b0001 << a;
            3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate narrow store data so every lane sees its own copy.
    function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {4{d[7:0]}};
            3'b001:  r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {a, 3'b000});
        h = 16'(w >> {a[1], 4'b0000});
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign unused_addr_hi_s = ^bus.ALUResultM[31:AW+2];

    // Request decode, handshake and array-operation strobes.
    always_comb begin
        err_s    = 1'b0;
        accept_s = 1'b0;
        busy_s   = 1'b0;
        if (reset && (state_r == ST_IDLE) && bus.MemReqM) begin
            err_s    = req_illegal(bus.MemWriteM, bus.funct3M, bus.ALUResultM[1:0]);
            accept_s = ~err_s;
        end else begin
            err_s    = 1'b0;
            accept_s = 1'b0;
        end
        if (state_r == ST_ACCESS) begin
            busy_s = 1'b1;
        end else begin
            busy_s = accept_s;
        end
        mem_op_s = (state_r == ST_ACCESS) && (cnt_r == 3'd0);
        lanes_s  = lane_mask(funct3_r, offs_r);
    end

    assign bus.ErrM      = err_s;
    assign bus.BusyM     = busy_s;
    assign bus.DoneM     = done_r;
    assign bus.ReadDataM = rdata_r;

    // Access sequencer with registered done pulse and load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 3'd0;
            write_r  <= 1'b0;
            funct3_r <= 3'b000;
            offs_r   <= 2'b00;
            index_r  <= '0;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    if (accept_s) begin
                        write_r  <= bus.MemWriteM;
                        funct3_r <= bus.funct3M;
                        offs_r   <= bus.ALUResultM[1:0];
                        index_r  <= bus.ALUResultM[AW+1:2];
                        wdata_r  <= store_align(bus.funct3M, bus.WriteDataM);
                        cnt_r    <= 3'(WAIT_STATES);
                        state_r  <= ST_ACCESS;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r != 3'd0) begin
                        cnt_r <= cnt_r - 3'd1;
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        rdata_r <= write_r ? 32'h0000_0000
                                           : load_extend(funct3_r, offs_r, mem_r[index_r]);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane store into the unreset array; reset forces IDLE so no write leaks.
    always_ff @(posedge clk) begin
        if (mem_op_s && write_r) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_s[i]) begin
                    mem_r[index_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait states
// share one request driver; a selector routes the request and observed outputs.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, rst3;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          sel;

    logic [31:0] rdata_s;
    logic        busy_s, done_s, err_s;

    int checks   = 0;
    int failures = 0;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();

    assign bus0.MemReqM = req & (sel == 0);
    assign bus1.MemReqM = req & (sel == 1);
    assign bus3.MemReqM = req & (sel == 3);
    assign bus0.MemWriteM = we;   assign bus1.MemWriteM = we;   assign bus3.MemWriteM = we;
    assign bus0.funct3M = f3;     assign bus1.funct3M = f3;     assign bus3.funct3M = f3;
    assign bus0.ALUResultM = addr; assign bus1.ALUResultM = addr; assign bus3.ALUResultM = addr;
    assign bus0.WriteDataM = wdata; assign bus1.WriteDataM = wdata; assign bus3.WriteDataM = wdata;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(rst0), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(rst1), .bus(bus1));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(rst3), .bus(bus3));

    always_comb begin
        case (sel)
            0: begin rdata_s = bus0.ReadDataM; busy_s = bus0.BusyM; done_s = bus0.DoneM; err_s = bus0.ErrM; end
            3: begin rdata_s = bus3.ReadDataM; busy_s = bus3.BusyM; done_s = bus3.DoneM; err_s = bus3.ErrM; end
            default: begin rdata_s = bus1.ReadDataM; busy_s = bus1.BusyM; done_s = bus1.DoneM; err_s = bus1.ErrM; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until DoneM, then confirm the pulse is one cycle wide.
    task automatic access(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int busy_n, output int done_at);
        @(posedge clk); #1;
        req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        busy_n = 0; done_at = -1; rd = 32'h0;
        for (int c = 0; c < 16 && done_at < 0; c++) begin
            @(negedge clk);
            if (busy_s) busy_n++;
            if (done_s) begin done_at = c; rd = rdata_s; end
            if (c == 0) chk({tag, "_err"}, {31'h0, err_s}, 32'h0);
            @(posedge clk); #1;
        end
        req = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, {31'h0, done_s}, 32'h0);
        chk({tag, "_rd_idle"}, rdata_s, 32'h0);
    endtask

    task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; int b; int d;
        access(tag, 1'b0, f, a, 32'h0, rd, b, d);
        chk(tag, rd, exp);
    endtask

    task automatic store(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] v);
        logic [31:0] rd; int b; int d;
        access(tag, 1'b1, f, a, v, rd, b, d);
        chk({tag, "_rd"}, rd, 32'h0);
    endtask

    task automatic bad(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a);
        @(posedge clk); #1;
        req = 1'b1; we = w; f3 = f; addr = a; wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk({tag, "_err"}, {31'h0, err_s}, 32'h1);
            chk({tag, "_busy"}, {31'h0, busy_s}, 32'h0);
            chk({tag, "_done"}, {31'h0, done_s}, 32'h0);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int bn, da;
        rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
        req = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0; sel = 1;

        #12;
        chk("rst_busy", {31'h0, busy_s}, 32'h0);
        chk("rst_done", {31'h0, done_s}, 32'h0);
        chk("rst_err", {31'h0, err_s}, 32'h0);
        chk("rst_rdata", rdata_s, 32'h0);
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;

        access("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, bn, da);
        chk("sw10_busy_cycles", 32'(bn), 32'd3);
        chk("sw10_done_cycle", 32'(da), 32'd3);
        chk("sw10_rd", rd, 32'h0);
        load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF);

        store("sb12", 3'b000, 32'h12, 32'h0000_00A5);
        load("lw10_merge", 3'b010, 32'h10, 32'hDEA5_BEEF);
        load("lb12", 3'b000, 32'h12, 32'hFFFF_FFA5);
        load("lbu12", 3'b100, 32'h12, 32'h0000_00A5);
        load("lb13", 3'b000, 32'h13, 32'hFFFF_FFDE);
        load("lbu11", 3'b100, 32'h11, 32'h0000_00BE);
        load("lh10", 3'b001, 32'h10, 32'hFFFF_BEEF);
        load("lhu12", 3'b101, 32'h12, 32'h0000_DEA5);

        store("sh16", 3'b001, 32'h16, 32'h1234_8001);
        load("lh16", 3'b001, 32'h16, 32'hFFFF_8001);
        load("lhu16", 3'b101, 32'h16, 32'h0000_8001);
        access("lw14", 1'b0, 3'b010, 32'h14, 32'h0, rd, bn, da);
        chk("lw14_upper", {16'h0, rd[31:16]}, 32'h0000_8001);

        bad("lw13_misal", 1'b0, 3'b010, 32'h13);
        bad("sh11_misal", 1'b1, 3'b001, 32'h11);
        bad("f3_011", 1'b0, 3'b011, 32'h10);
        bad("sbu_store", 1'b1, 3'b100, 32'h10);
        load("lw10_after_err", 3'b010, 32'h10, 32'hDEA5_BEEF);

        store("sw1000", 3'b010, 32'h1000, 32'h0000_0055);
        load("lw0_wrap", 3'b010, 32'h0, 32'h0000_0055);

        sel = 0;
        access("ws0_sw40", 1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, rd, bn, da);
        chk("ws0_busy_cycles", 32'(bn), 32'd2);
        chk("ws0_done_cycle", 32'(da), 32'd2);
        load("ws0_lw40", 3'b010, 32'h40, 32'h0BAD_F00D);

        sel = 3;
        access("ws3_sw20", 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, rd, bn, da);
        chk("ws3_busy_cycles", 32'(bn), 32'd5);
        chk("ws3_done_cycle", 32'(da), 32'd5);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("abort_busy_before", {31'h0, busy_s}, 32'h1);
        rst3 = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy_s}, 32'h0);
        chk("abort_done", {31'h0, done_s}, 32'h0);
        chk("abort_rdata", rdata_s, 32'h0);
        f3 = 3'b011; we = 1'b0;
        #1;
        chk("abort_err_in_reset", {31'h0, err_s}, 32'h0);
        req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        load("ws3_lw20_prior", 3'b010, 32'h20, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
